// File: rtl/buck_pwm_pkg.sv
// Shared constants, channel state encoding and duty clamp helper for the
// two-phase interleaved buck PWM generator.
package buck_pwm_pkg;

  // Default timing, all in clk cycles.
  localparam logic [15:0] DefPeriod = 16'd400;  // 4 us switching period
  localparam logic [15:0] DefPhase  = 16'd200;  // channel-1 offset, 180 degrees
  localparam logic [15:0] DefDead   = 16'd5;    // dead time between gate edges
  localparam logic [15:0] DefMaxOn  = 16'd200;  // duty ceiling
  localparam logic [15:0] DefMinOn  = 16'd4;    // shortest non-zero HS pulse

  // Per-channel gate state.
  typedef enum logic [2:0] {
    StOff  = 3'd0,
    StHsOn = 3'd1,
    StDt1  = 3'd2,
    StLsOn = 3'd3,
    StDt2  = 3'd4
  } chan_state_e;

  // Clamp a requested on-time: cap at max_on, and drop pulses too short to
  // switch cleanly to zero.
  function automatic logic [15:0] clamp_duty(input logic [15:0] req,
                                             input logic [15:0] max_on,
                                             input logic [15:0] min_on);
    logic [15:0] res;
    if (req > max_on) begin
      res = max_on;
    end else if ((req != 16'd0) && (req < min_on)) begin
      res = 16'd0;
    end else begin
      res = req;
    end
    return res;
  endfunction

endpackage

// File: rtl/buck_pwm_channel.sv
// One buck phase: duty shadow latch with clamp, gate FSM and registered
// complementary gate outputs with dead-time insertion.
module buck_pwm_channel
  import buck_pwm_pkg::*;
#(
  parameter logic [15:0] PERIOD = DefPeriod,
  parameter logic [15:0] DEAD   = DefDead,
  parameter logic [15:0] MAX_ON = DefMaxOn,
  parameter logic [15:0] MIN_ON = DefMinOn
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] count,         // this channel's period counter
  input  logic [15:0] duty_req,      // requested HS on-time
  input  logic        run_req,       // enable already qualified by fault latch
  input  logic        kill,          // fault input or latched fault
  output logic        hs_gate,
  output logic        ls_gate,
  output logic        period_start
);

  logic [15:0] duty_q;
  logic        run_q;
  logic        latch_pt;
  chan_state_e state_q, state_d;
  chan_state_e region;
  logic        hs_q, hs_d;
  logic        ls_q, ls_d;
  logic        ps_q;

  assign latch_pt = (count == (PERIOD - 16'd1));

  // Shadow duty and run flag; sampled once per period on its last cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_q <= 16'd0;
      run_q  <= 1'b0;
    end else if (latch_pt) begin
      duty_q <= clamp_duty(duty_req, MAX_ON, MIN_ON);
      run_q  <= run_req;
    end
  end

  // Where in the period the counter sits for the current shadow duty.
  // With duty 0 the first compare never hits, so DT1 opens the period.
  always_comb begin
    region = StDt2;
    if (count < duty_q) begin
      region = StHsOn;
    end else if (count < (duty_q + DEAD)) begin
      region = StDt1;
    end else if (count < (PERIOD - DEAD)) begin
      region = StLsOn;
    end else begin
      region = StDt2;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StOff;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: fault wins, a period start decides run/off, an idle channel
  // stays idle until the next period start.
  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = StOff;
    end else if (count == 16'd0) begin
      state_d = run_q ? region : StOff;
    end else if (state_q == StOff) begin
      state_d = StOff;
    end else begin
      state_d = region;
    end
  end

  // Gate decode from the next state; only one state drives each gate, so
  // HS and LS can never be high together.
  always_comb begin
    hs_d = 1'b0;
    ls_d = 1'b0;
    unique case (state_d)
      StHsOn:  hs_d = 1'b1;
      StLsOn:  ls_d = 1'b1;
      default: begin
        hs_d = 1'b0;
        ls_d = 1'b0;
      end
    endcase
  end

  // Registered gates and period-start pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_q <= 1'b0;
      ls_q <= 1'b0;
      ps_q <= 1'b0;
    end else begin
      hs_q <= hs_d;
      ls_q <= ls_d;
      ps_q <= (count == 16'd0);
    end
  end

  assign hs_gate      = hs_q;
  assign ls_gate      = ls_q;
  assign period_start = ps_q;

endmodule

// File: rtl/buck_pwm_generator.sv
// Two-phase interleaved buck PWM generator: master and 180-degree period
// counters, sticky fault latch, and two gate-drive channels.
module buck_pwm_generator
  import buck_pwm_pkg::*;
#(
  parameter logic [15:0] PERIOD = DefPeriod,
  parameter logic [15:0] PHASE  = DefPhase,
  parameter logic [15:0] DEAD   = DefDead,
  parameter logic [15:0] MAX_ON = DefMaxOn,
  parameter logic [15:0] MIN_ON = DefMinOn
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        fault,
  input  logic        fault_clr,
  input  logic [15:0] inductor_charging_time,
  output logic [15:0] timer_buck_4us_0,
  output logic [15:0] timer_buck_4us_180,
  output logic [1:0]  hs_gate,
  output logic [1:0]  ls_gate,
  output logic        fault_latched,
  output logic [1:0]  period_start
);

  // Keeping the LS window non-empty needs MAX_ON + 2*DEAD <= PERIOD.
  if ((32'(MAX_ON) + 32'd2 * 32'(DEAD)) > 32'(PERIOD)) begin : g_bad_dead_time
    $error("MAX_ON + 2*DEAD must not exceed PERIOD");
  end
  if (PHASE >= PERIOD) begin : g_bad_phase
    $error("PHASE must be below PERIOD");
  end
  if (MIN_ON > MAX_ON) begin : g_bad_min_on
    $error("MIN_ON must not exceed MAX_ON");
  end

  logic [15:0] master_q, master_d;
  logic [15:0] phase_q, phase_d;
  logic        fault_q, fault_d;
  logic        run_req;
  logic        kill;

  // Wrapping counters; the phase counter is its own register so it always
  // equals (master + PHASE) mod PERIOD without an adder on the output.
  always_comb begin
    master_d = (master_q == (PERIOD - 16'd1)) ? 16'd0 : master_q + 16'd1;
    phase_d  = (phase_q == (PERIOD - 16'd1)) ? 16'd0 : phase_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      master_q <= 16'd0;
      phase_q  <= PHASE;
    end else begin
      master_q <= master_d;
      phase_q  <= phase_d;
    end
  end

  // Fault latch next state: set beats clear, clear only with fault low.
  always_comb begin
    fault_d = fault_q;
    if (fault) begin
      fault_d = 1'b1;
    end else if (fault_clr) begin
      fault_d = 1'b0;
    end
  end

  // Fault latch register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  // Raw fault is included so the gates drop one cycle after the fault edge.
  assign kill    = fault | fault_q;
  assign run_req = enable & ~fault_q;

  buck_pwm_channel #(
    .PERIOD (PERIOD),
    .DEAD   (DEAD),
    .MAX_ON (MAX_ON),
    .MIN_ON (MIN_ON)
  ) u_ch0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .count        (master_q),
    .duty_req     (inductor_charging_time),
    .run_req      (run_req),
    .kill         (kill),
    .hs_gate      (hs_gate[0]),
    .ls_gate      (ls_gate[0]),
    .period_start (period_start[0])
  );

  buck_pwm_channel #(
    .PERIOD (PERIOD),
    .DEAD   (DEAD),
    .MAX_ON (MAX_ON),
    .MIN_ON (MIN_ON)
  ) u_ch1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .count        (phase_q),
    .duty_req     (inductor_charging_time),
    .run_req      (run_req),
    .kill         (kill),
    .hs_gate      (hs_gate[1]),
    .ls_gate      (ls_gate[1]),
    .period_start (period_start[1])
  );

  assign timer_buck_4us_0   = master_q;
  assign timer_buck_4us_180 = phase_q;
  assign fault_latched      = fault_q;

endmodule

// File: tb/tb_buck_pwm_generator.sv
// Directed bench for buck_pwm_generator: per-period gate shape, clamping,
// shadow latching, fault latch, enable gating and mid-period reset.
module tb_buck_pwm_generator;

  localparam int Period = 400;
  localparam int ActNone    = 0;
  localparam int ActDuty    = 1;
  localparam int ActDisable = 2;
  localparam int ActEnable  = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        fault;
  logic        fault_clr;
  logic [15:0] ict;
  logic [15:0] timer0;
  logic [15:0] timer180;
  logic [1:0]  hs_gate;
  logic [1:0]  ls_gate;
  logic        fault_latched;
  logic [1:0]  period_start;

  int n_checks = 0;
  int n_fail   = 0;
  int m_hs, m_ls, m_ls_first, m_ls_last, m_overlap;

  always #5 clk = ~clk;

  buck_pwm_generator u_dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .enable                 (enable),
    .fault                  (fault),
    .fault_clr              (fault_clr),
    .inductor_charging_time (ict),
    .timer_buck_4us_0       (timer0),
    .timer_buck_4us_180     (timer180),
    .hs_gate                (hs_gate),
    .ls_gate                (ls_gate),
    .fault_latched          (fault_latched),
    .period_start           (period_start)
  );

  task automatic check_val(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic wait_start(input logic ch);
    int n = 0;
    while (!period_start[ch] && n < 2 * Period) begin
      @(negedge clk);
      n++;
    end
    if (!period_start[ch]) check_val("period_start_timeout", 0, 1);
  endtask

  task automatic wait_timer0(input int v);
    int n = 0;
    while (int'(timer0) != v && n < 2 * Period) begin
      @(negedge clk);
      n++;
    end
    check_val("timer0_reached", int'(timer0), v);
  endtask

  // Sample index i sees the gates decoded from counter value i.
  task automatic measure(input logic ch, input int act_at, input int act, input int val);
    wait_start(ch);
    m_hs = 0; m_ls = 0; m_overlap = 0; m_ls_first = -1; m_ls_last = -1;
    for (int i = 0; i < Period; i++) begin
      if (hs_gate[ch]) m_hs++;
      if (ls_gate[ch]) begin
        m_ls++;
        if (m_ls_first < 0) m_ls_first = i;
        m_ls_last = i;
      end
      if ((hs_gate & ls_gate) != 2'b00) m_overlap++;
      if (i == act_at) begin
        case (act)
          ActDuty:    ict = 16'(val);
          ActDisable: enable = 1'b0;
          ActEnable:  enable = 1'b1;
          default:    ;
        endcase
      end
      @(negedge clk);
    end
  endtask

  task automatic expect_period(input string tag, input int hs, input int ls,
                               input int ls_first, input int ls_last);
    check_val({tag, "_hs_cycles"}, m_hs, hs);
    check_val({tag, "_ls_cycles"}, m_ls, ls);
    check_val({tag, "_ls_first"}, m_ls_first, ls_first);
    check_val({tag, "_ls_last"}, m_ls_last, ls_last);
    check_val({tag, "_overlap"}, m_overlap, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_timer0"}, int'(timer0), 0);
    check_val({tag, "_timer180"}, int'(timer180), 200);
    check_val({tag, "_hs"}, int'(hs_gate), 0);
    check_val({tag, "_ls"}, int'(ls_gate), 0);
    check_val({tag, "_fault_latched"}, int'(fault_latched), 0);
    check_val({tag, "_period_start"}, int'(period_start), 0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; fault = 1'b0; fault_clr = 1'b0; ict = 16'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");

    // Release with enable: first period is off because run resets to 0.
    enable = 1'b1; ict = 16'd120; rst_n = 1'b1;
    measure(1'b0, -1, ActNone, 0);
    expect_period("first_off", 0, 0, -1, -1);
    measure(1'b0, -1, ActNone, 0);
    expect_period("duty120", 120, 270, 125, 394);

    // Channel 1 starts 200 counts later.
    wait_start(1'b1);
    check_val("ch1_offset", int'(timer0), 201);
    measure(1'b1, -1, ActNone, 0);
    expect_period("ch1_duty120", 120, 270, 125, 394);

    // 350 is clamped to 200; set here it is latched at the end of this period.
    ict = 16'd350;
    measure(1'b0, -1, ActNone, 0);
    expect_period("clamp350", 200, 190, 205, 394);

    // 3 is below MIN_ON; the current period still uses the clamped 200.
    ict = 16'd3;
    measure(1'b0, -1, ActNone, 0);
    expect_period("clamp_hold", 200, 190, 205, 394);
    measure(1'b0, 49, ActDuty, 100);
    expect_period("min_on_zero", 0, 390, 5, 394);

    // Change 100 -> 150 at counter 50: current period keeps 100.
    measure(1'b0, 49, ActDuty, 150);
    expect_period("duty100_hold", 100, 290, 105, 394);
    measure(1'b0, -1, ActNone, 0);
    expect_period("duty150", 150, 240, 155, 394);

    // Fault at counter 60 during HS.
    wait_timer0(60);
    check_val("pre_fault_hs", int'(hs_gate[0]), 1);
    fault = 1'b1;
    @(negedge clk);
    check_val("fault_hs_off", int'(hs_gate), 0);
    check_val("fault_ls_off", int'(ls_gate), 0);
    check_val("fault_latch_set", int'(fault_latched), 1);
    fault_clr = 1'b1;
    @(negedge clk);
    fault = 1'b0; fault_clr = 1'b0;
    check_val("clr_ignored", int'(fault_latched), 1);
    @(negedge clk);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check_val("clr_taken", int'(fault_latched), 0);
    check_val("off_after_clr", int'(hs_gate | ls_gate), 0);
    measure(1'b0, -1, ActNone, 0);
    expect_period("resume", 150, 240, 155, 394);

    // Disable at counter 10: this period completes, next is off, then resume.
    measure(1'b0, 9, ActDisable, 0);
    expect_period("disable_finish", 150, 240, 155, 394);
    measure(1'b0, 100, ActEnable, 0);
    expect_period("disabled_off", 0, 0, -1, -1);
    measure(1'b0, -1, ActNone, 0);
    expect_period("reenabled", 150, 240, 155, 394);

    // Reset during LS_ON.
    wait_timer0(250);
    check_val("pre_rst_ls", int'(ls_gate[0]), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_val("restart_timer0", int'(timer0), 1);
    check_val("restart_timer180", int'(timer180), 201);
    measure(1'b0, -1, ActNone, 0);
    expect_period("post_rst_off", 0, 0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
